// File: rtl/fault_inject_ctrl_if.sv
// Request, frame-buffer and reconfiguration signals of fault_inject_ctrl.
// slave is the controller side; master is the requester / buffer / config side.
interface fault_inject_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_bit;
  logic [12:0] buf_addr;
  logic [31:0] buf_rdata;
  logic [31:0] buf_wdata;
  logic        buf_we;
  logic        cfg_req;
  logic        cfg_ack;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] last_word;

  modport master (
    output req_valid, req_bit, buf_rdata, cfg_ack,
    input  req_ready, buf_addr, buf_wdata, buf_we, cfg_req, busy, done, err, last_word
  );

  modport slave (
    input  req_valid, req_bit, buf_rdata, cfg_ack,
    output req_ready, buf_addr, buf_wdata, buf_we, cfg_req, busy, done, err, last_word
  );
endinterface

// File: rtl/fault_inject_ctrl.sv
// Single-bit fault injector: read-modify-write of one frame word, then a reconfiguration handshake.
// FI_RESTORE_EN adds a write-back of the original word and a second reconfiguration exchange.
module fault_inject_ctrl #(
  parameter int FRAME_OFFSET = 105,
  parameter int FRAME_WORDS  = 101,
  parameter int ACK_TIMEOUT  = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  fault_inject_ctrl_if.slave    io
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RD     = 4'd1;
  localparam logic [3:0] S_WT     = 4'd2;
  localparam logic [3:0] S_WR     = 4'd3;
  localparam logic [3:0] S_CFG    = 4'd4;
  localparam logic [3:0] S_CWAIT  = 4'd5;
  localparam logic [3:0] S_DONE   = 4'd6;
`ifdef FI_RESTORE_EN
  localparam logic [3:0] S_RWR    = 4'd7;
  localparam logic [3:0] S_RCFG   = 4'd8;
  localparam logic [3:0] S_RCWAIT = 4'd9;
`endif

  localparam int          CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [12:0] OFF      = 13'(FRAME_OFFSET);
  localparam logic [31:0] FW       = 32'(FRAME_WORDS);

  logic [3:0]    state_q, state_d;
  logic [12:0]   addr_q, addr_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [6:0]    word_idx;
  logic          timed_out;
`ifdef FI_RESTORE_EN
  logic [31:0]   word_q, word_d;
`endif

  assign word_idx  = io.req_bit[11:5];
  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef FI_RESTORE_EN
    word_d  = word_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (io.req_valid) begin
          if ({25'd0, word_idx} >= FW) begin
            err_d = 1'b1;
          end else begin
            addr_d  = OFF + {6'd0, word_idx};
            bit_d   = io.req_bit[4:0];
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_WT;
      S_WT: begin
        // Flipped word is registered here so buf_wdata and last_word are stable in WR.
        wdata_d = io.buf_rdata ^ (32'd1 << bit_q);
        last_d  = wdata_d;
`ifdef FI_RESTORE_EN
        word_d  = io.buf_rdata;
`endif
        state_d = S_WR;
      end
      S_WR: state_d = S_CFG;
      S_CFG: begin
        cnt_d   = '0;
        state_d = S_CWAIT;
      end
      S_CWAIT: begin
        if (io.cfg_ack) begin
`ifdef FI_RESTORE_EN
          wdata_d = word_q;
          state_d = S_RWR;
`else
          state_d = S_DONE;
`endif
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef FI_RESTORE_EN
      S_RWR: state_d = S_RCFG;
      S_RCFG: begin
        cnt_d   = '0;
        state_d = S_RCWAIT;
      end
      S_RCWAIT: begin
        if (io.cfg_ack) begin
          state_d = S_DONE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      bit_q   <= '0;
      wdata_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef FI_RESTORE_EN
      word_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef FI_RESTORE_EN
      word_q  <= word_d;
`endif
    end
  end

  assign io.req_ready = (state_q == S_IDLE) && !rst;
  assign io.buf_addr  = addr_q;
  assign io.buf_wdata = wdata_q;
  assign io.last_word = last_q;
  assign io.busy      = (state_q != S_IDLE);
  assign io.done      = (state_q == S_DONE);
  assign io.err       = err_q;
`ifdef FI_RESTORE_EN
  assign io.buf_we    = (state_q == S_WR) || (state_q == S_RWR);
  assign io.cfg_req   = (state_q == S_CFG) || (state_q == S_CWAIT) ||
                        (state_q == S_RCFG) || (state_q == S_RCWAIT);
`else
  assign io.buf_we    = (state_q == S_WR);
  assign io.cfg_req   = (state_q == S_CFG) || (state_q == S_CWAIT);
`endif

endmodule

// File: tb/tb_fault_inject_ctrl.sv
// Bench for fault_inject_ctrl: directed vector table, reset sequences and randomized requests
// checked against a transaction-level model (handles builds with and without FI_RESTORE_EN).
module tb_fault_inject_ctrl;
  localparam int TMO   = 16;
  localparam int LIMIT = 2 * TMO + 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fault_inject_ctrl_if bus ();

  fault_inject_ctrl #(.FRAME_OFFSET(105), .FRAME_WORDS(101), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  // Frame buffer: one-cycle read latency, preload port for the bench.
  logic [31:0] mem [0:8191];
  logic        pl_en = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    bus.buf_rdata <= mem[bus.buf_addr];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.buf_we) mem[bus.buf_addr] <= bus.buf_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  int r_err, r_done, r_nwr, r_ncfg, r_widx0;
  logic r_stuck, r_ready;
  logic [12:0] r_a;
  logic [31:0] r_w0, r_w1, r_last;

  typedef struct {
    logic [11:0] rb;
    int d1;
    int d2;
    logic [31:0] pre;
    int e_err;
    int e_done;
    int e_nwr;
    logic [12:0] e_a;
    logic [31:0] e_w0;
    logic [31:0] e_w1;
    int e_ncfg;
  } vec_t;
  vec_t vecs [8];

  function automatic vec_t mk(input logic [11:0] rb, input int d1, input int d2, input logic [31:0] pre,
                              input int e_err, input int e_done, input int e_nwr, input logic [12:0] e_a,
                              input logic [31:0] e_w0, input logic [31:0] e_w1, input int e_ncfg);
    vec_t v;
    v.rb = rb; v.d1 = d1; v.d2 = d2; v.pre = pre; v.e_err = e_err; v.e_done = e_done;
    v.e_nwr = e_nwr; v.e_a = e_a; v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_ncfg = e_ncfg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [12:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!bus.req_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.req_ready) begin
      chk("idle_wait", 0, 1);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  // One transaction; d<0 never acks (d=-1 acks only in the CFG cycle), else ack on CWAIT cycle d.
  task automatic run_txn(input logic [11:0] rb, input int d1, input int d2);
    int hi, nexch, dsel;
    bit fin;
    wait_idle();
    r_err = 0; r_done = 0; r_nwr = 0; r_ncfg = 0; r_widx0 = 0;
    r_a = '0; r_w0 = '0; r_w1 = '0;
    hi = 0; nexch = 0; fin = 1'b0;
    bus.req_bit = rb; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int idx = 1; idx <= LIMIT && !fin; idx++) begin
      if (bus.buf_we) begin
        if (r_nwr == 0) begin
          r_a = bus.buf_addr; r_w0 = bus.buf_wdata; r_widx0 = idx;
        end else begin
          r_w1 = bus.buf_wdata;
        end
        r_nwr++;
      end
      if (bus.cfg_req) begin
        if (hi == 0) begin nexch++; r_ncfg++; end
        hi++;
      end else begin
        hi = 0;
      end
      dsel = (nexch == 2) ? d2 : d1;
      bus.cfg_ack = bus.cfg_req && (hi == dsel + 2);
      if (bus.done) begin r_done = idx; fin = 1'b1; end
      if (bus.err)  begin r_err = idx;  fin = 1'b1; end
      @(posedge clk); #1;
    end
    bus.cfg_ack = 1'b0;
    r_stuck = bus.done | bus.err;
    r_ready = bus.req_ready;
    r_last  = bus.last_word;
  endtask

  task automatic verify(input string nm, input int e_err, input int e_done, input int e_nwr,
                        input logic [12:0] e_a, input logic [31:0] e_w0, input logic [31:0] e_w1,
                        input int e_ncfg);
    chk({nm, ".err_cycle"}, r_err, e_err);
    chk({nm, ".done_cycle"}, r_done, e_done);
    chk({nm, ".writes"}, r_nwr, e_nwr);
    chk({nm, ".cfg_reqs"}, r_ncfg, e_ncfg);
    chk({nm, ".pulse_len"}, r_stuck, 0);
    chk({nm, ".ready_after"}, r_ready, 1);
    if (e_nwr > 0) begin
      chk({nm, ".addr"}, r_a, e_a);
      chk({nm, ".wdata0"}, r_w0, e_w0);
      chk({nm, ".we_cycle"}, r_widx0, 3);
      chk({nm, ".last_word"}, r_last, e_w0);
    end
    if (e_nwr > 1) chk({nm, ".wdata1"}, r_w1, e_w1);
  endtask

  // Transaction-level expectation from the request rules.
  task automatic model(input logic [11:0] rb, input int d1, input int d2, input logic [31:0] orig,
                       output int e_err, output int e_done, output int e_nwr, output logic [12:0] e_a,
                       output logic [31:0] e_w0, output logic [31:0] e_w1, output int e_ncfg);
    int wi, bi;
    wi = int'(rb) / 32;
    bi = int'(rb) % 32;
    e_err = 0; e_done = 0; e_nwr = 0; e_a = '0; e_w0 = '0; e_w1 = '0; e_ncfg = 0;
    if (wi >= 101) begin
      e_err = 1;
    end else begin
      e_a = 13'(105 + wi);
      e_w0 = orig ^ (32'd1 << bi);
      e_nwr = 1; e_ncfg = 1;
      if (d1 < 0 || d1 >= TMO) begin
        e_err = 5 + TMO;
      end else begin
`ifdef FI_RESTORE_EN
        e_nwr = 2; e_w1 = orig; e_ncfg = 2;
        if (d2 < 0 || d2 >= TMO) e_err = 8 + d1 + TMO;
        else e_done = 9 + d1 + d2;
`else
        e_done = 6 + d1;
`endif
      end
    end
  endtask

  initial begin
    int e_err, e_done, e_nwr, e_ncfg, d1, d2;
    logic [12:0] e_a;
    logic [31:0] e_w0, e_w1, orig;
    logic [11:0] rb;

    bus.req_valid = 1'b0; bus.req_bit = '0; bus.cfg_ack = 1'b0;

`ifdef FI_RESTORE_EN
    vecs[0] = mk(12'd37,   0,  0, 32'h0000_0000,  0,  9, 2, 13'd106, 32'h0000_0020, 32'h0000_0000, 2);
    vecs[3] = mk(12'd3231, 15, 0, 32'h0000_0001,  0, 24, 2, 13'd205, 32'h8000_0001, 32'h0000_0001, 2);
    vecs[5] = mk(12'd0,    0,  0, 32'hFFFF_FFFF,  0,  9, 2, 13'd105, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2);
    vecs[7] = mk(12'd160,  0, -2, 32'hA5A5_A5A5, 24,  0, 2, 13'd110, 32'hA5A5_A5A4, 32'hA5A5_A5A5, 2);
`else
    vecs[0] = mk(12'd37,   0,  0, 32'h0000_0000,  0,  6, 1, 13'd106, 32'h0000_0020, 32'h0, 1);
    vecs[3] = mk(12'd3231, 15, 0, 32'h0000_0001,  0, 21, 1, 13'd205, 32'h8000_0001, 32'h0, 1);
    vecs[5] = mk(12'd0,    0,  0, 32'hFFFF_FFFF,  0,  6, 1, 13'd105, 32'hFFFF_FFFE, 32'h0, 1);
    vecs[7] = mk(12'd160,  0, -2, 32'hA5A5_A5A5,  0,  6, 1, 13'd110, 32'hA5A5_A5A4, 32'h0, 1);
`endif
    vecs[1] = mk(12'd3232, 0,  0, 32'h0000_0000,  1,  0, 0, 13'd0,   32'h0,         32'h0, 0);
    vecs[2] = mk(12'd0,   -2,  0, 32'h1234_5678, 21,  0, 1, 13'd105, 32'h1234_5679, 32'h0, 1);
    vecs[4] = mk(12'd0,   -1,  0, 32'h0000_0000, 21,  0, 1, 13'd105, 32'h0000_0001, 32'h0, 1);
    vecs[6] = mk(12'd3200, 16, 0, 32'h0000_0000, 21,  0, 1, 13'd205, 32'h0000_0001, 32'h0, 1);

    // Reset: outputs cleared and req_ready held low while rst is high.
    @(posedge clk); #1;
    chk("reset.req_ready", bus.req_ready, 0);
    chk("reset.outputs", {bus.buf_we, bus.cfg_req, bus.done, bus.err, bus.busy,
                          bus.buf_addr, bus.buf_wdata, bus.last_word}, '0);
    rst = 1'b0;
    #10;
    chk("reset.ready_after", bus.req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      preload(13'(105 + int'(vecs[i].rb) / 32), vecs[i].pre);
      run_txn(vecs[i].rb, vecs[i].d1, vecs[i].d2);
      verify($sformatf("vec%0d", i), vecs[i].e_err, vecs[i].e_done, vecs[i].e_nwr,
             vecs[i].e_a, vecs[i].e_w0, vecs[i].e_w1, vecs[i].e_ncfg);
    end

    // Reset during CWAIT aborts the exchange; a fresh request then completes.
    preload(13'd106, 32'h0);
    wait_idle();
    bus.req_bit = 12'd37; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("cwait_rst.pre_cfg_req", bus.cfg_req, 1);
    chk("cwait_rst.pre_busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("cwait_rst.cfg_req", bus.cfg_req, 0);
    chk("cwait_rst.busy", bus.busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("cwait_rst.no_we", bus.buf_we, 0);
    preload(13'd106, 32'h0);
    run_txn(12'd37, 0, 0);
    model(12'd37, 0, 0, 32'h0, e_err, e_done, e_nwr, e_a, e_w0, e_w1, e_ncfg);
    verify("cwait_rst.after", e_err, e_done, e_nwr, e_a, e_w0, e_w1, e_ncfg);

    for (int i = 0; i < 40; i++) begin
      rb   = 12'($urandom_range(0, 4095));
      d1   = int'($urandom_range(0, TMO + 2)) - 2;
      d2   = int'($urandom_range(0, TMO + 2)) - 2;
      orig = $urandom;
      preload(13'(105 + int'(rb) / 32), orig);
      run_txn(rb, d1, d2);
      model(rb, d1, d2, orig, e_err, e_done, e_nwr, e_a, e_w0, e_w1, e_ncfg);
      verify($sformatf("rnd%0d", i), e_err, e_done, e_nwr, e_a, e_w0, e_w1, e_ncfg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fault_inject_ctrl.md
FAULT_INJECT_CTRL -- requirements
Module: fault_inject_ctrl

Interface
REQ-001 SHALL have parameter FRAME_OFFSET, default 105: frame-buffer address of word 0 of the target frame.
REQ-002 SHALL have parameter FRAME_WORDS, default 101: number of valid words per frame.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1023: maximum number of cycles to wait for cfg_ack.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit; and port req_ready, output, 1 bit: injection-request handshake.
REQ-007 SHALL have port req_bit, input, 12 bits: bit location within the frame.
REQ-008 SHALL have port buf_addr, output, 13 bits: frame-buffer address.
REQ-009 SHALL have port buf_rdata, input, 32 bits: frame-buffer read data, valid 1 cycle after buf_addr.
REQ-010 SHALL have ports buf_wdata, output, 32 bits; and buf_we, output, 1 bit: frame-buffer write.
REQ-011 SHALL have port cfg_req, output, 1 bit; and port cfg_ack, input, 1 bit: request reconfiguration and receive its completion pulse.
REQ-012 SHALL have outputs busy (1 bit), done (1-cycle pulse), err (1-cycle pulse) and last_word (32 bits, the modified word).

Function
REQ-013 SHALL compute word_index = req_bit[11:5], bit_index = req_bit[4:0] and target address = FRAME_OFFSET + word_index, with 13-bit unsigned arithmetic.
REQ-014 SHALL accept a request when req_valid && req_ready; req_ready SHALL be high only in IDLE.
REQ-015 SHALL reject a request with word_index >= FRAME_WORDS by pulsing err on the cycle after acceptance; it SHALL then return to IDLE without asserting buf_we or cfg_req.
REQ-016 SHALL use the FSM IDLE -> RD -> WT -> WR -> CFG -> CWAIT -> DONE -> IDLE.
REQ-017 SHALL drive buf_addr to the target address in RD, and capture buf_rdata in WT.
REQ-018 SHALL pulse buf_we for exactly 1 cycle in WR, with buf_wdata = captured word XOR (1 << bit_index); last_word SHALL be updated to the same value.
REQ-019 SHALL hold cfg_req high from CFG until cfg_ack is sampled high; cfg_ack outside CWAIT SHALL be ignored.
REQ-020 SHALL, if cfg_ack is not seen within ACK_TIMEOUT cycles of CWAIT, pulse err, drop cfg_req and return to IDLE.
REQ-021 SHALL pulse done for 1 cycle in DONE; busy SHALL be high in every state except IDLE.
REQ-022 SHALL, if cfg_ack arrives on the same cycle the timeout expires, treat it as success.
REQ-023 SHALL have a best-case latency of 6 cycles from acceptance to done when cfg_ack arrives on the first CWAIT cycle.

Reset
REQ-024 SHALL, on rst, enter IDLE and clear buf_we, cfg_req, done, err, busy, buf_addr, buf_wdata, last_word and the timeout counter at the next clk edge.
REQ-025 SHALL allow rst in any state, including mid-write or mid-CWAIT, to abort the operation with no further buf_we or cfg_req.
REQ-026 SHALL hold req_ready low during the reset cycle.

Configuration
REQ-027 SHALL, when FI_RESTORE_EN is defined, follow the first cfg_ack by writing the original captured word back to the same address (1-cycle buf_we) and performing a second cfg_req/cfg_ack exchange with the same timeout, before asserting done.
REQ-028 SHALL, when FI_RESTORE_EN is undefined, omit the restore states and logic and leave the fault persistent.

Verification
REQ-029 SHALL cover: req_bit=12'd37 with buf_rdata=32'h0000_0000 -> buf_addr=106, buf_wdata=32'h0000_0020, cfg_req asserted, cfg_ack -> done after 6 cycles.
REQ-030 SHALL cover: req_bit=12'd3232 (word_index 101) -> err pulse, with no buf_we and no cfg_req.
REQ-031 SHALL cover: cfg_ack never returned -> err exactly ACK_TIMEOUT cycles into CWAIT, then req_ready high.
REQ-032 SHALL cover: rst asserted during CWAIT -> cfg_req low and busy low after 1 edge, and a new request accepted afterwards.
REQ-033 SHALL cover, with FI_RESTORE_EN and req_bit=12'd0, buf_rdata=32'hFFFF_FFFF: first write 32'hFFFF_FFFE, second write 32'hFFFF_FFFF, two cfg_req exchanges, then done.
